spi_master: RTL
===============

Name: spi_master

Overview:
- SPI master that drives the team's SPI slave: generates ss_n, load, busy and s_clk, shifts MOSI out and captures MISO, MSB first, reg_width bits per transfer.
- Sits between the system bus side (start, d_in_master, d_out_master) and the slave's serial and control pins.
- s_clk is a registered output in the clk domain, because the slave samples s_clk synchronously on clk.

Parameters:
- reg_width, 32, bits per transfer; must equal the slave's reg_width.
- high_cyc, 2, clk cycles s_clk stays high per bit; minimum 1.

Ports:
- clk  input  1  system clock, shared with the slave.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a transfer; sampled only in IDLE.
- d_in_master  input  reg_width  word to transmit; captured on the accepted start.
- MISO  input  1  serial data from the slave.
- ss_n  output  1  slave select, active low.
- load  output  1  one-cycle strobe; slave latches its own d_in_slave.
- busy  output  1  high during the shift and done phases.
- s_clk  output  1  serial clock; idles high.
- MOSI  output  1  serial data to the slave, MSB first.
- d_out_master  output  reg_width  received word.
- done_master  output  1  one-cycle pulse; d_out_master is valid.
- ready  output  1  high when in IDLE and able to accept start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ss_n=1, s_clk=1, busy=0, load=0, MOSI=0, done_master=0, d_out_master=0, internal tx/rx registers=0, bit counter=0.
- Reset mid-transfer aborts immediately to these values. No partial word is reported.
- All outputs are registered. Let E0 be the edge that samples start=1 in IDLE.
- IDLE: ready=1. On start, latch d_in_master into tx_reg and go to SELECT (ss_n=0 from E0).
- SELECT: 1 cycle of ss_n setup. Go to LOAD (load=1 from E1).
- LOAD: load=1 for exactly 1 cycle. Go to SHIFT_HI (E2).
- SHIFT_HI: busy=1, s_clk=1, MOSI=tx_reg[reg_width-1]. Hold for high_cyc cycles, then go to SHIFT_LO.
- SHIFT_LO: s_clk=0 for exactly 1 cycle. This is mandatory: the slave shifts on every clk while s_clk is low.
  - On the edge leaving SHIFT_LO: rx_reg <= {rx_reg[reg_width-2:0], MISO}, tx_reg shifts left, bit counter +1.
  - If counter reaches reg_width, go to DONE; else return to SHIFT_HI.
- MOSI is stable across the whole high phase and the low cycle of each bit. MISO is sampled on the edge where s_clk=0 (the slave updated it during the high phase).
- DONE: busy=1, s_clk=1, ss_n=0 for 2 cycles, so the slave registers d_out_slave and done_slave. load stays 0 throughout.
- RELEASE: 1 cycle. ss_n=1, busy=0, d_out_master<=rx_reg, done_master=1. Next state is IDLE.
- Timing, default parameters: done_master is high in the cycle after edge E0+100, computed as 2 + reg_width*(high_cyc+1) + 2.
- Counter width is clog2(reg_width)+1. There is no wrap within a transfer.
- start outside IDLE is ignored, not queued.
- Back-to-back transfers: start held high during RELEASE is seen in IDLE one cycle later, giving a minimum 1 idle cycle between transfers.
- load and busy are never high together.

Optional Feature:
- Macro: SPI_XFER_CNT_EN.
- Defined:
  - Adds output xfer_cnt[15:0].
  - Increments on each done_master pulse and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 mid-SHIFT_HI, then release -> ss_n=1, s_clk=1, busy=0, load=0, MOSI=0, done_master=0, ready=1.
- Single transfer with a slave model that echoes:
  - Setup: d_in_master=32'hA5C3_0F96, slave loaded with 32'h1234_5678, start at E0.
  - Expect: load high only in cycle E1..E2.
  - Expect: done_master pulses once, after E0+100.
  - Expect: d_out_master=32'h1234_5678 and slave d_out_slave=32'hA5C3_0F96.
- Bit timing, high_cyc=1, reg_width=8, d_in_master=8'h81:
  - Expect: MOSI pattern 1,0,0,0,0,0,0,1.
  - Expect: exactly 8 single-cycle s_clk lows and a 2+16+2-cycle transfer.
- Busy-ignore: pulse start again at E0+10 -> no effect, exactly one done_master, ready=0 until IDLE.
- Back-to-back: hold start=1 continuously with words 32'hFFFF_FFFF then 32'h0 -> two done_master pulses 102 cycles apart, ss_n high for at least 2 cycles between them.
- With SPI_XFER_CNT_EN defined: 3 transfers -> xfer_cnt=3; after rst=0 -> xfer_cnt=0.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: SPI master for the companion SPI slave. It generates ss_n, load,
// busy and s_clk, shifts MOSI out MSB first and captures MISO into d_out_master,
// reg_width bits per transfer. s_clk is a registered clk-domain signal because
// the slave samples it synchronously on the same clk.
// Optional feature: define SPI_XFER_CNT_EN to add the xfer_cnt[15:0] output, a
// saturating count of completed transfers.
module spi_master #(
   parameter int reg_width = 32,
   parameter int high_cyc  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [reg_width-1:0] d_in_master,
   input  logic                 MISO,
   output logic                 ss_n,
   output logic                 load,
   output logic                 busy,
   output logic                 s_clk,
   output logic                 MOSI,
   output logic [reg_width-1:0] d_out_master,
   output logic                 done_master,
   output logic                 ready
`ifdef SPI_XFER_CNT_EN
   ,
   output logic [15:0]          xfer_cnt
`endif
);

   // Bit counter must hold the value reg_width itself (no wrap within a word).
   localparam int CNT_W = $clog2(reg_width) + 1;
   // Phase counter covers both the high_cyc high phase and the 2-cycle DONE hold.
   localparam int PH_W  = $clog2(high_cyc + 2);

   localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(reg_width);
   localparam logic [PH_W-1:0]  HI_LAST   = PH_W'(high_cyc - 1);
   localparam logic [PH_W-1:0]  DONE_LAST = PH_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      LOAD     = 3'd2,
      SHIFT_HI = 3'd3,
      SHIFT_LO = 3'd4,
      DONE     = 3'd5,
      RELEASE  = 3'd6
   } state_t;

   state_t               state_reg, state_next;
   logic [PH_W-1:0]      phase_reg, phase_next;
   logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
   logic [reg_width-1:0] tx_reg, tx_next;
   logic [reg_width-1:0] rx_reg, rx_next;

   // Next values of the registered outputs, decoded from the next state so every
   // output changes on the same edge as the state it belongs to.
   logic                 ss_n_next;
   logic                 load_next;
   logic                 busy_next;
   logic                 s_clk_next;
   logic                 mosi_next;
   logic [reg_width-1:0] d_out_next;
   logic                 done_next;
   logic                 ready_next;

   // State register together with all datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         phase_reg    <= '0;
         bit_cnt_reg  <= '0;
         tx_reg       <= '0;
         rx_reg       <= '0;
         ss_n         <= 1'b1;
         load         <= 1'b0;
         busy         <= 1'b0;
         s_clk        <= 1'b1;
         MOSI         <= 1'b0;
         d_out_master <= '0;
         done_master  <= 1'b0;
         ready        <= 1'b1;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         bit_cnt_reg  <= bit_cnt_next;
         tx_reg       <= tx_next;
         rx_reg       <= rx_next;
         ss_n         <= ss_n_next;
         load         <= load_next;
         busy         <= busy_next;
         s_clk        <= s_clk_next;
         MOSI         <= mosi_next;
         d_out_master <= d_out_next;
         done_master  <= done_next;
         ready        <= ready_next;
      end
   end

   // Next-state and datapath update: sequencing of select, load, bit shifting and release.
   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg;
      bit_cnt_next = bit_cnt_reg;
      tx_next      = tx_reg;
      rx_next      = rx_reg;
      case (state_reg)
         IDLE: begin
            // start is only honoured here; requests in any other state are dropped.
            if (start) begin
               state_next   = SELECT;
               tx_next      = d_in_master;
               bit_cnt_next = '0;
            end
         end
         SELECT: begin
            state_next = LOAD;
         end
         LOAD: begin
            state_next = SHIFT_HI;
            phase_next = '0;
         end
         SHIFT_HI: begin
            if (phase_reg == HI_LAST) begin
               state_next = SHIFT_LO;
               phase_next = '0;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         SHIFT_LO: begin
            // MISO was updated by the slave during the high phase; take it now,
            // on the edge that ends the single low cycle.
            rx_next      = {rx_reg[reg_width-2:0], MISO};
            tx_next      = {tx_reg[reg_width-2:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            phase_next   = '0;
            if (bit_cnt_next == BITS_LAST) begin
               state_next = DONE;
            end else begin
               state_next = SHIFT_HI;
            end
         end
         DONE: begin
            // Two cycles with ss_n low and s_clk high so the slave can register its result.
            if (phase_reg == DONE_LAST) begin
               state_next = RELEASE;
               phase_next = '0;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode from the next state; MOSI follows the head of the next shift word.
   always_comb begin
      ss_n_next  = 1'b1;
      load_next  = 1'b0;
      busy_next  = 1'b0;
      s_clk_next = 1'b1;
      mosi_next  = 1'b0;
      d_out_next = d_out_master;
      done_next  = 1'b0;
      ready_next = 1'b0;
      case (state_next)
         IDLE: begin
            ready_next = 1'b1;
         end
         SELECT: begin
            ss_n_next = 1'b0;
         end
         LOAD: begin
            ss_n_next = 1'b0;
            load_next = 1'b1;
         end
         SHIFT_HI: begin
            ss_n_next = 1'b0;
            busy_next = 1'b1;
            mosi_next = tx_next[reg_width-1];
         end
         SHIFT_LO: begin
            ss_n_next  = 1'b0;
            busy_next  = 1'b1;
            s_clk_next = 1'b0;
            mosi_next  = tx_next[reg_width-1];
         end
         DONE: begin
            ss_n_next = 1'b0;
            busy_next = 1'b1;
         end
         RELEASE: begin
            d_out_next = rx_next;
            done_next  = 1'b1;
         end
         default: begin
            ready_next = 1'b0;
         end
      endcase
   end

`ifdef SPI_XFER_CNT_EN
   // Saturating count of completed transfers, stepping together with done_master.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xfer_cnt <= '0;
      end else if (done_next && (xfer_cnt != 16'hFFFF)) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule
